// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
//
// Purpose: conditions raw board switch/button levels for the processor's
// GPIO input port. Each bit passes through a two-flop synchronizer into the
// clk_i domain. It is then debounced by its own stability counter, so a new
// level is accepted only after it has persisted for DEBOUNCE_CYCLES
// consecutive synchronized cycles. Accepted changes also produce registered
// one-cycle rise/fall pulses.
//
// Ports:
//   clk_i      in   system clock (same clock as the processor core)
//   reset_i    in   asynchronous, active-low reset; clears every flop
//   raw_i      in   [WIDTH]  raw asynchronous pin levels
//   GPIO_o     out  [WIDTH]  debounced stable levels (to core GPIO_i)
//   rise_o     out  [WIDTH]  one-cycle pulse when GPIO_o[n] goes 0->1
//   fall_o     out  [WIDTH]  one-cycle pulse when GPIO_o[n] goes 1->0
//   changed_o  out           one-cycle pulse when any GPIO_o bit changed
//
// Parameters:
//   WIDTH            number of conditioned bits
//   DEBOUNCE_CYCLES  stable cycles required, legal 1..2^CNT_WIDTH-1
//   CNT_WIDTH        width of each per-bit stability counter

module gpio_in_conditioner #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH       = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] GPIO_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             changed_o
);

   // Terminal count: a differing level is accepted on the edge where the
   // counter already holds this value, giving DEBOUNCE_CYCLES clean cycles.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]     s1;
   logic [WIDTH-1:0]     s2;
   logic [WIDTH-1:0]     stable;
   logic [WIDTH-1:0]     rise;
   logic [WIDTH-1:0]     fall;
   logic [CNT_WIDTH-1:0] cnt [WIDTH];

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         s1     <= '0;
         s2     <= '0;
         stable <= '0;
         rise   <= '0;
         fall   <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         // Synchronizer: straight flop-to-flop, no logic between stages.
         s1 <= raw_i;
         s2 <= s1;

         // Pulses default low; only an accepting bit raises one.
         rise <= '0;
         fall <= '0;

         // Per-bit debounce. Any cycle where s2 matches the stable level
         // clears the count, so a bounce restarts the clean-run requirement.
         for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
               rise[i]   <= s2[i];
               fall[i]   <= ~s2[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign GPIO_o    = stable;
   assign rise_o    = rise;
   assign fall_o    = fall;
   // Only combinational output, and it depends on registered pulses only.
   assign changed_o = |(rise | fall);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Testbench for gpio_in_conditioner: directed vectors with hand-computed
// expectations on three instances (DEBOUNCE_CYCLES = 4, 1 and 8).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so "edge e" below counts rising edges after an input change.

module tb_gpio_in_conditioner;

   logic       clk;
   logic       rst4;
   logic       rst8;
   logic [7:0] raw4, raw1, raw8;
   logic [7:0] gpio4, rise4, fall4;
   logic [7:0] gpio1, rise1, fall1;
   logic [7:0] gpio8, rise8, fall8;
   logic       chg4, chg1, chg8;

   int n_vec = 0;
   int n_err = 0;

   gpio_in_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) u_dut4 (
      .clk_i(clk), .reset_i(rst4), .raw_i(raw4),
      .GPIO_o(gpio4), .rise_o(rise4), .fall_o(fall4), .changed_o(chg4)
   );

   gpio_in_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(16)) u_dut1 (
      .clk_i(clk), .reset_i(rst4), .raw_i(raw1),
      .GPIO_o(gpio1), .rise_o(rise1), .fall_o(fall1), .changed_o(chg1)
   );

   gpio_in_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(8), .CNT_WIDTH(16)) u_dut8 (
      .clk_i(clk), .reset_i(rst8), .raw_i(raw8),
      .GPIO_o(gpio8), .rise_o(rise8), .fall_o(fall8), .changed_o(chg8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_edges(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int seq [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
      int n_rise;

      // ---------------- Reset with inputs high ----------------
      rst4 = 1'b0; rst8 = 1'b0;
      raw4 = 8'hFF; raw1 = 8'h00; raw8 = 8'h00;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rst_gpio", gpio4, 8'h00);
         chk("rst_rise", rise4, 8'h00);
         chk("rst_chg", chg4, 1'b0);
         step();
      end
      chk("rst_gpio8", gpio8, 8'h00);
      rst4 = 1'b1; rst8 = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         chk($sformatf("rel_gpio_e%0d", e), gpio4, (e >= 6) ? 8'hFF : 8'h00);
         chk($sformatf("rel_rise_e%0d", e), rise4, (e == 6) ? 8'hFF : 8'h00);
         chk($sformatf("rel_chg_e%0d", e), chg4, (e == 6) ? 1'b1 : 1'b0);
      end

      // ---------------- Clean fall on bit 3 ----------------
      raw4 = 8'hF7;
      for (int e = 1; e <= 8; e++) begin
         step();
         chk($sformatf("fall_gpio_e%0d", e), gpio4, (e >= 6) ? 8'hF7 : 8'hFF);
         chk($sformatf("fall_fall_e%0d", e), fall4, (e == 6) ? 8'h08 : 8'h00);
         chk($sformatf("fall_rise_e%0d", e), rise4, 8'h00);
      end

      // ---------------- Glitch rejection ----------------
      raw4 = 8'h00;
      wait_edges(8);
      chk("glitch_pre_gpio", gpio4, 8'h00);
      raw4 = 8'h01;
      for (int e = 1; e <= 12; e++) begin
         if (e == 4) raw4 = 8'h00;
         step();
         chk($sformatf("glitch_gpio_e%0d", e), gpio4, 8'h00);
         chk($sformatf("glitch_rise_e%0d", e), rise4, 8'h00);
         chk($sformatf("glitch_chg_e%0d", e), chg4, 1'b0);
      end

      // ---------------- Bounce on bit 1 ----------------
      n_rise = 0;
      for (int e = 1; e <= 14; e++) begin
         raw4 = (e <= 9 && seq[e-1] == 0) ? 8'h00 : 8'h02;
         step();
         if (rise4[1]) n_rise++;
         chk($sformatf("bounce_gpio_e%0d", e), gpio4, (e >= 11) ? 8'h02 : 8'h00);
         chk($sformatf("bounce_rise_e%0d", e), rise4, (e == 11) ? 8'h02 : 8'h00);
      end
      chk("bounce_rise_count", n_rise, 1);

      // ---------------- Simultaneous bits ----------------
      raw4 = 8'h00;
      wait_edges(8);
      chk("simul_pre_gpio", gpio4, 8'h00);
      raw4 = 8'h81;
      for (int e = 1; e <= 8; e++) begin
         step();
         chk($sformatf("simul_gpio_e%0d", e), gpio4, (e >= 6) ? 8'h81 : 8'h00);
         chk($sformatf("simul_rise_e%0d", e), rise4, (e == 6) ? 8'h81 : 8'h00);
         chk($sformatf("simul_chg_e%0d", e), chg4, (e == 6) ? 1'b1 : 1'b0);
      end

      // ---------------- DEBOUNCE_CYCLES = 1: sync + edge detect ----------------
      raw1 = 8'h01;
      for (int e = 1; e <= 4; e++) begin
         step();
         chk($sformatf("d1_gpio_e%0d", e), gpio1, (e >= 3) ? 8'h01 : 8'h00);
         chk($sformatf("d1_rise_e%0d", e), rise1, (e == 3) ? 8'h01 : 8'h00);
      end
      raw1 = 8'h00;
      for (int e = 1; e <= 4; e++) begin
         step();
         chk($sformatf("d1f_gpio_e%0d", e), gpio1, (e >= 3) ? 8'h00 : 8'h01);
         chk($sformatf("d1f_fall_e%0d", e), fall1, (e == 3) ? 8'h01 : 8'h00);
      end

      // ---------------- Asynchronous reset between edges ----------------
      rst4 = 1'b0;
      #1;
      chk("async_gpio", gpio4, 8'h00);
      chk("async_rise", rise4, 8'h00);
      step();
      rst4 = 1'b1;

      // ---------------- Reset mid-count, DEBOUNCE_CYCLES = 8 ----------------
      raw8 = 8'h04;
      for (int e = 1; e <= 5; e++) begin
         step();
         chk($sformatf("mid_gpio_e%0d", e), gpio8, 8'h00);
      end
      rst8 = 1'b0;
      for (int e = 1; e <= 2; e++) begin
         step();
         chk($sformatf("mid_rst_gpio_e%0d", e), gpio8, 8'h00);
         chk($sformatf("mid_rst_rise_e%0d", e), rise8, 8'h00);
      end
      rst8 = 1'b1;
      n_rise = 0;
      for (int e = 1; e <= 13; e++) begin
         step();
         if (rise8[2]) n_rise++;
         chk($sformatf("mid_gpio_rel_e%0d", e), gpio8, (e >= 10) ? 8'h04 : 8'h00);
         chk($sformatf("mid_rise_rel_e%0d", e), rise8, (e == 10) ? 8'h04 : 8'h00);
         chk($sformatf("mid_chg_rel_e%0d", e), chg8, (e == 10) ? 1'b1 : 1'b0);
      end
      chk("mid_rise_count", n_rise, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
